// File: rtl/dmm_copy_engine.sv
// Block-copy engine: reads up to BURST_MAX words into a local buffer, writes them back out,
// and repeats until the requested byte count has been moved (forward copy only).
module dmm_copy_engine #(
  parameter int unsigned BURST_MAX = 8,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              copy_start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] copy_len,
  output logic              copy_active,
  output logic              copy_done,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic [3:0]        mem_rd_len,
  input  logic              mem_rd_valid,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [3:0]        mem_wr_len,
  output logic [31:0]       mem_wr_data,
  input  logic              mem_wr_valid
);

  // Beat counters must reach BURST_MAX (up to 16), so they carry one bit more than the index.
  localparam int unsigned CntW = 5;
  localparam int unsigned IdxW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdData,
    StWrReq,
    StWrData,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [CntW-1:0]   beats_q, beats_d;
  logic [CntW-1:0]   rd_idx_q, rd_idx_d;
  logic [CntW-1:0]   wr_idx_q, wr_idx_d;
  logic [31:0]       buf_q [BURST_MAX];
  logic              buf_we;

  logic [ADDR_W-1:0] words;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] rem_after;
  logic [CntW-1:0]   beats_m1;
  logic              unused_bits;

  function automatic logic [CntW-1:0] burst_of(input logic [ADDR_W-1:0] rem);
    if (rem >= ADDR_W'(BURST_MAX)) begin
      return CntW'(BURST_MAX);
    end
    return rem[CntW-1:0];
  endfunction

  assign words       = {2'b00, copy_len[ADDR_W-1:2]};
  assign step        = ADDR_W'(beats_q) << 2;
  assign rem_after   = remaining_q - ADDR_W'(beats_q);
  assign beats_m1    = beats_q - CntW'(1);
  assign unused_bits = ^{copy_len[1:0], src_addr[1:0], dst_addr[1:0], beats_m1[CntW-1:4]};

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    remaining_d = remaining_q;
    beats_d     = beats_q;
    rd_idx_d    = rd_idx_q;
    wr_idx_d    = wr_idx_q;
    buf_we      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (copy_start) begin
          src_d       = {src_addr[ADDR_W-1:2], 2'b00};
          dst_d       = {dst_addr[ADDR_W-1:2], 2'b00};
          remaining_d = words;
          if (words == '0) begin
            state_d = StDone;
          end else begin
            beats_d  = burst_of(words);
            rd_idx_d = '0;
            state_d  = StRdReq;
          end
        end
      end
      StRdReq: state_d = StRdData;
      StRdData: begin
        if (mem_rd_valid) begin
          buf_we   = 1'b1;
          rd_idx_d = rd_idx_q + CntW'(1);
          if (rd_idx_d == beats_q) begin
            wr_idx_d = '0;
            state_d  = StWrReq;
          end
        end
      end
      StWrReq: state_d = StWrData;
      StWrData: begin
        if (mem_wr_valid) begin
          wr_idx_d = wr_idx_q + CntW'(1);
          if (wr_idx_d == beats_q) begin
            src_d       = src_q + step;
            dst_d       = dst_q + step;
            remaining_d = rem_after;
            if (rem_after == '0) begin
              state_d = StDone;
            end else begin
              beats_d  = burst_of(rem_after);
              rd_idx_d = '0;
              state_d  = StRdReq;
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      src_q       <= '0;
      dst_q       <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      rd_idx_q    <= '0;
      wr_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      remaining_q <= remaining_d;
      beats_q     <= beats_d;
      rd_idx_q    <= rd_idx_d;
      wr_idx_q    <= wr_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(BURST_MAX); i++) begin
        buf_q[i] <= '0;
      end
    end else if (buf_we) begin
      buf_q[rd_idx_q[IdxW-1:0]] <= mem_rd_data;
    end
  end

  // Address/length/data outputs are gated to their phase so idle and reset present all zeros.
  always_comb begin
    copy_active = (state_q != StIdle);
    copy_done   = (state_q == StDone);
    mem_rd_req  = (state_q == StRdReq);
    mem_wr_req  = (state_q == StWrReq);
    mem_rd_addr = mem_rd_req ? src_q : '0;
    mem_rd_len  = mem_rd_req ? beats_m1[3:0] : '0;
    mem_wr_addr = mem_wr_req ? dst_q : '0;
    mem_wr_len  = mem_wr_req ? beats_m1[3:0] : '0;
    mem_wr_data = (state_q == StWrData) ? buf_q[wr_idx_q[IdxW-1:0]] : '0;
  end

endmodule

// File: tb/tb_dmm_copy_engine.sv
// Directed bench for dmm_copy_engine with a zero-wait memory slave model that can stall writes.
module tb_dmm_copy_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        copy_start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [31:0] copy_len = '0;
  logic        copy_active, copy_done;
  logic        mem_rd_req, mem_wr_req;
  logic [31:0] mem_rd_addr, mem_wr_addr, mem_wr_data;
  logic [3:0]  mem_rd_len, mem_wr_len;
  logic        mem_rd_valid = 1'b0;
  logic [31:0] mem_rd_data = '0;
  logic        mem_wr_valid = 1'b0;

  dmm_copy_engine #(.BURST_MAX(8), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .copy_start   (copy_start),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .copy_len     (copy_len),
    .copy_active  (copy_active),
    .copy_done    (copy_done),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_len   (mem_rd_len),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_req   (mem_wr_req),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_len   (mem_wr_len),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_valid (mem_wr_valid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] rd_addr_q[$], wr_addr_q[$], wr_data_q[$], wr_beat_addr_q[$];
  logic [3:0]  rd_len_q[$], wr_len_q[$];
  int          rd_cyc_q[$], wr_cyc_q[$];
  int          done_cnt = 0, done_cyc = -1, pulse_viol = 0;
  logic        prev_rd = 1'b0, prev_wr = 1'b0;

  int          rd_cnt = 0, wr_cnt = 0, wr_beat = 0;
  logic [31:0] rd_ptr = '0, wr_ptr = '0, stall_ref = '0;
  int          stall_beat = -1, stall_left = 0;
  logic        stalling = 1'b0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor and slave: observe DUT outputs mid-cycle, drive responses for the next edge.
  always @(negedge clk) begin
    if (rst) begin
      rd_cnt = 0; wr_cnt = 0; stalling = 1'b0;
      mem_rd_valid = 1'b0; mem_wr_valid = 1'b0;
      prev_rd = 1'b0; prev_wr = 1'b0;
    end else begin
      if (mem_rd_req && mem_wr_req) pulse_viol++;
      if (mem_rd_req && prev_rd) pulse_viol++;
      if (mem_wr_req && prev_wr) pulse_viol++;
      prev_rd = mem_rd_req;
      prev_wr = mem_wr_req;
      if (copy_done) begin done_cnt++; done_cyc = cyc - t0; end
      if (mem_rd_req) begin
        rd_addr_q.push_back(mem_rd_addr); rd_len_q.push_back(mem_rd_len); rd_cyc_q.push_back(cyc - t0);
      end
      if (mem_wr_req) begin
        wr_addr_q.push_back(mem_wr_addr); wr_len_q.push_back(mem_wr_len); wr_cyc_q.push_back(cyc - t0);
      end

      if (rd_cnt > 0) begin
        mem_rd_valid = 1'b1; mem_rd_data = word_of(rd_ptr); rd_ptr += 4; rd_cnt--;
      end else begin
        mem_rd_valid = 1'b0; mem_rd_data = '0;
      end
      if (mem_rd_req) begin rd_ptr = mem_rd_addr; rd_cnt = int'(mem_rd_len) + 1; end

      if (wr_cnt > 0 && stall_left > 0 && wr_beat == stall_beat) begin
        mem_wr_valid = 1'b0;
        if (stalling) check("wr_data_hold", mem_wr_data, stall_ref);
        else begin stalling = 1'b1; stall_ref = mem_wr_data; end
        stall_left--;
      end else if (wr_cnt > 0) begin
        if (stalling) begin check("wr_data_after_stall", mem_wr_data, stall_ref); stalling = 1'b0; end
        mem_wr_valid = 1'b1;
        wr_data_q.push_back(mem_wr_data); wr_beat_addr_q.push_back(wr_ptr);
        wr_ptr += 4; wr_cnt--; wr_beat++;
      end else begin
        mem_wr_valid = 1'b0;
      end
      if (mem_wr_req) begin wr_ptr = mem_wr_addr; wr_cnt = int'(mem_wr_len) + 1; wr_beat = 0; end
    end
  end

  task automatic clear_log();
    rd_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete(); wr_beat_addr_q.delete();
    rd_len_q.delete(); wr_len_q.delete(); rd_cyc_q.delete(); wr_cyc_q.delete();
    done_cnt = 0; done_cyc = -1;
  endtask

  // Returns at the negedge of cycle 1 (start is driven during cycle 0).
  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    @(negedge clk);
    src_addr = s; dst_addr = d; copy_len = l; copy_start = 1'b1; t0 = cyc;
    @(negedge clk);
    copy_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (copy_done !== 1'b1 && n < limit) begin @(negedge clk); n++; end
    check({tag, "_done_seen"}, 32'(copy_done), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_data(input string tag, input logic [31:0] s, input logic [31:0] d,
                            input int nwords);
    int bad = 0;
    check({tag, "_wr_beats"}, wr_data_q.size(), nwords);
    for (int i = 0; i < nwords && i < wr_data_q.size(); i++) begin
      if (wr_data_q[i] !== word_of(s + 32'(4 * i))) bad++;
      if (wr_beat_addr_q[i] !== d + 32'(4 * i)) bad++;
    end
    check({tag, "_data_mismatches"}, bad, 0);
  endtask

  initial begin
    int n;
    int rd_sz, wr_sz;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_active", 32'(copy_active), 0);
    check("rst_done", 32'(copy_done), 0);
    check("rst_rd_req", 32'(mem_rd_req), 0);
    check("rst_wr_req", 32'(mem_wr_req), 0);
    check("rst_wr_data", mem_wr_data, 0);

    // Zero-length copy: immediate done, no traffic.
    clear_log();
    start_copy(32'h7000_0100, 32'h7000_0400, 32'd0);
    check("len0_done_c1", 32'(copy_done), 1);
    check("len0_active_c1", 32'(copy_active), 1);
    @(negedge clk);
    check("len0_active_c2", 32'(copy_active), 0);
    repeat (3) @(negedge clk);
    check("len0_rd_bursts", rd_addr_q.size(), 0);
    check("len0_wr_bursts", wr_addr_q.size(), 0);

    // Single 8-word burst.
    clear_log();
    start_copy(32'h7000_0100, 32'h7000_0400, 32'd32);
    wait_done("b8", 200);
    check("b8_rd_bursts", rd_addr_q.size(), 1);
    check("b8_rd_addr", rd_addr_q[0], 32'h7000_0100);
    check("b8_rd_len", 32'(rd_len_q[0]), 7);
    check("b8_rd_cyc", rd_cyc_q[0], 1);
    check("b8_wr_addr", wr_addr_q[0], 32'h7000_0400);
    check("b8_wr_len", 32'(wr_len_q[0]), 7);
    check("b8_wr_cyc", wr_cyc_q[0], 10);
    check("b8_done_cyc", done_cyc, 19);
    check("b8_done_cnt", done_cnt, 1);
    check_data("b8", 32'h7000_0100, 32'h7000_0400, 8);

    // 11 words: full burst then 3-word tail.
    clear_log();
    start_copy(32'h7000_0100, 32'h7000_0400, 32'd44);
    wait_done("b11", 300);
    check("b11_rd_bursts", rd_addr_q.size(), 2);
    check("b11_rd_addr0", rd_addr_q[0], 32'h7000_0100);
    check("b11_rd_len0", 32'(rd_len_q[0]), 7);
    check("b11_rd_addr1", rd_addr_q[1], 32'h7000_0120);
    check("b11_rd_len1", 32'(rd_len_q[1]), 2);
    check("b11_wr_addr0", wr_addr_q[0], 32'h7000_0400);
    check("b11_wr_len0", 32'(wr_len_q[0]), 7);
    check("b11_wr_addr1", wr_addr_q[1], 32'h7000_0420);
    check("b11_wr_len1", 32'(wr_len_q[1]), 2);
    check("b11_done_cyc", done_cyc, 27);
    check_data("b11", 32'h7000_0100, 32'h7000_0400, 11);

    // Unaligned src/dst and ragged length.
    clear_log();
    start_copy(32'h7000_0203, 32'h7000_0803, 32'h13);
    wait_done("ua", 200);
    check("ua_rd_addr", rd_addr_q[0], 32'h7000_0200);
    check("ua_rd_len", 32'(rd_len_q[0]), 3);
    check("ua_wr_addr", wr_addr_q[0], 32'h7000_0800);
    check_data("ua", 32'h7000_0200, 32'h7000_0800, 4);

    // Write stall of 5 cycles at beat 3 plus stray starts while busy.
    clear_log();
    stall_beat = 3; stall_left = 5;
    start_copy(32'h7000_0100, 32'h7000_0400, 32'd32);
    repeat (4) @(negedge clk);
    copy_start = 1'b1;
    @(negedge clk);
    copy_start = 1'b0;
    repeat (6) @(negedge clk);
    copy_start = 1'b1;
    @(negedge clk);
    copy_start = 1'b0;
    wait_done("st", 300);
    repeat (5) @(negedge clk);
    check("st_done_cnt", done_cnt, 1);
    check("st_done_cyc", done_cyc, 24);
    check("st_idle_after", 32'(copy_active), 0);
    check("st_rd_bursts", rd_addr_q.size(), 1);
    check_data("st", 32'h7000_0100, 32'h7000_0400, 8);
    stall_beat = -1; stall_left = 0;

    // Reset in WR_DATA aborts; then a fresh 2-word copy.
    clear_log();
    start_copy(32'h7000_0100, 32'h7000_0400, 32'd32);
    n = 0;
    while (wr_cyc_q.size() == 0 && n < 100) begin @(negedge clk); n++; end
    check("rs_wr_req_seen", wr_cyc_q.size(), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rs_active", 32'(copy_active), 0);
    check("rs_done", 32'(copy_done), 0);
    check("rs_rd_req", 32'(mem_rd_req), 0);
    check("rs_rd_addr", mem_rd_addr, 0);
    check("rs_rd_len", 32'(mem_rd_len), 0);
    check("rs_wr_req", 32'(mem_wr_req), 0);
    check("rs_wr_addr", mem_wr_addr, 0);
    check("rs_wr_len", 32'(mem_wr_len), 0);
    check("rs_wr_data", mem_wr_data, 0);
    @(negedge clk);
    rst = 1'b0;
    rd_sz = rd_addr_q.size();
    wr_sz = wr_addr_q.size();
    repeat (6) @(negedge clk);
    check("rs_no_rd_after", rd_addr_q.size(), rd_sz);
    check("rs_no_wr_after", wr_addr_q.size(), wr_sz);
    check("rs_still_idle", 32'(copy_active), 0);
    check("rs_no_done", done_cnt, 0);

    clear_log();
    start_copy(32'h7000_1000, 32'h7000_2000, 32'd8);
    wait_done("r2", 200);
    check("r2_rd_len", 32'(rd_len_q[0]), 1);
    check("r2_wr_len", 32'(wr_len_q[0]), 1);
    check("r2_done_cyc", done_cyc, 7);
    check("r2_done_cnt", done_cnt, 1);
    check_data("r2", 32'h7000_1000, 32'h7000_2000, 2);

    check("pulse_rules", pulse_viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmm_copy_engine.md
Name: dmm_copy_engine

Overview:
- Block-copy engine that sits directly downstream of the newlib-based allocator inside the memory manager.
- The allocator issues a copy (src_addr, dst_addr, copy_len) while servicing a reallocate request. This block moves the old chunk contents to the new chunk through a burst word-level master port, then returns copy_done.
- It buffers one read burst internally, then writes that burst back out, and repeats until the byte count is exhausted.

Parameters:
- BURST_MAX, 8: maximum words per burst and depth of the internal data buffer; legal range 1..16.
- ADDR_W, 32: address and length width.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- copy_start, input, 1: one-cycle request; sampled only in IDLE.
- src_addr, input, ADDR_W: source byte address; bits [1:0] forced to 0.
- dst_addr, input, ADDR_W: destination byte address; bits [1:0] forced to 0.
- copy_len, input, ADDR_W: byte count; bits [1:0] ignored.
- copy_active, output, 1: high in every non-IDLE state.
- copy_done, output, 1: one-cycle completion pulse.
- mem_rd_req, output, 1: one-cycle read-burst request.
- mem_rd_addr, output, ADDR_W: read-burst start address.
- mem_rd_len, output, 4: read beats minus 1.
- mem_rd_valid, input, 1: read beat present on mem_rd_data.
- mem_rd_data, input, 32: read beat data.
- mem_wr_req, output, 1: one-cycle write-burst request.
- mem_wr_addr, output, ADDR_W: write-burst start address.
- mem_wr_len, output, 4: write beats minus 1.
- mem_wr_data, output, 32: current write beat.
- mem_wr_valid, input, 1: slave accepted the current write beat this cycle.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs go to 0; state goes to IDLE.
  - Buffer and counters are cleared.
  - Reset mid-copy aborts immediately; no further requests are issued.
- Start (IDLE):
  - copy_start=1 latches src, dst and words = copy_len>>2.
  - words==0: go to DONE, with no memory traffic.
  - Otherwise go to RD_REQ.
  - copy_start in any other state is ignored.
- Burst size: beats = min(BURST_MAX, remaining words), computed on entry to RD_REQ.
- RD_REQ (1 cycle):
  - mem_rd_req=1, mem_rd_addr=cur_src, mem_rd_len=beats-1.
  - Next state: RD_DATA.
- RD_DATA:
  - Each mem_rd_valid writes mem_rd_data into buffer[rd_idx] and increments rd_idx.
  - On the beat where rd_idx reaches beats: go to WR_REQ.
  - mem_rd_valid in any other state is ignored.
- WR_REQ (1 cycle):
  - mem_wr_req=1, mem_wr_addr=cur_dst, mem_wr_len=beats-1.
  - Next state: WR_DATA.
- WR_DATA:
  - mem_wr_data = buffer[wr_idx], held stable until mem_wr_valid=1, then wr_idx increments.
  - On the final beat: cur_src += beats*4, cur_dst += beats*4, remaining -= beats.
  - Then: remaining==0 goes to DONE, else RD_REQ.
- DONE (1 cycle): copy_done=1, copy_active=1; next state IDLE, where copy_active=0.
- Address arithmetic: modulo 2^ADDR_W; wrap is not flagged.
- Copy direction: strictly ascending (forward) copy.
  - Correct for non-overlapping ranges, or when dst < src.
  - dst inside (src, src+len) is unsupported; the result is undefined.
- Pulse outputs: mem_rd_req and mem_wr_req are never high in the same cycle, and never high for two consecutive cycles.
- Latency, single burst of N words, zero-wait slave (start at cycle 0):
  - rd_req at cycle 1; read beats at cycles 2..N+1.
  - wr_req at cycle N+2; write beats at cycles N+3..2N+2.
  - copy_done at cycle 2N+3.

Test Plan:
- copy_start with copy_len=0 -> copy_done=1 at cycle 1; mem_rd_req and mem_wr_req never assert; copy_active low at cycle 2.
- src=0x70000100, dst=0x70000400, len=32 -> one read burst (addr 0x70000100, len 7) and one write burst (addr 0x70000400, len 7); written words equal the read words in order; copy_done at cycle 19 with a zero-wait slave.
- len=44, same addresses -> read bursts at 0x70000100 (len 7) then 0x70000120 (len 2); write bursts at 0x70000400 (len 7) then 0x70000420 (len 2); exactly 11 write beats total.
- len=0x13, src=0x70000203 -> src treated as 0x70000200; exactly 4 words copied; mem_rd_len=3.
- Slave holds mem_wr_valid=0 for 5 cycles mid-burst, and copy_start pulses during the copy -> mem_wr_data stable through the stall; the extra start is ignored; exactly one copy_done.
- rst=1 during WR_DATA -> next cycle all outputs 0 and state IDLE; a fresh copy_start with len=8 completes normally with 2 beats per direction.
